// File: rtl/sum_seq_ctrl.sv
// rtl/sum_seq_ctrl.sv - multi-cycle summation controller driving an external adder
module sum_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_ops,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    output logic [WIDTH-1:0] sum_out,
    output logic             sum_valid,
    output logic             carry_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum_out;
    logic [CNT_W-1:0] r_remaining;
    logic             r_carry;
    logic             w_start_job;
    logic             w_accept;
    logic             w_last;
    logic             w_wrap;

    assign w_start_job = (r_state == S_IDLE) && start && !abort;
    assign in_ready    = (r_state == S_ACC) && !abort;
    assign w_accept    = in_ready && in_valid;
    assign w_last      = (r_remaining == CNT_W'(1));
    // With cin tied low, an unsigned sum below operand A means the add wrapped.
    assign w_wrap      = add_s < r_acc;

    assign add_a      = r_acc;
    assign add_b      = (r_state == S_ACC) ? in_data : '0;
    assign add_cin    = 1'b0;
    assign sum_out    = r_sum_out;
    assign carry_flag = r_carry;
    assign sum_valid  = (r_state == S_DONE) && !abort;
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_job) begin
                    w_next = (n_ops == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Result is captured on entry to DONE so it lines up with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sum_out   <= '0;
            r_remaining <= '0;
            r_carry     <= 1'b0;
        end else if (w_start_job) begin
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_remaining <= n_ops;
            if (n_ops == '0) begin
                r_sum_out <= '0;
            end
        end else if (w_accept) begin
            r_acc       <= add_s;
            r_remaining <= r_remaining - CNT_W'(1);
            r_carry     <= r_carry | w_wrap;
            if (w_last) begin
                r_sum_out <= add_s;
            end
        end
    end

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb/tb_sum_seq_ctrl.sv - directed and randomized check of sum_seq_ctrl against an arithmetic model
module tb_sum_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  n_ops;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_s;
    logic [31:0] sum_out;
    logic        sum_valid;
    logic        carry_flag;
    logic        busy;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          hs_cnt = 0;
    int          sv_cnt = 0;
    logic [31:0] q_ops[$];
    int          q_gaps[$];
    logic [31:0] last_sum = 32'd0;
    int          hs0;
    int          sv0;

    always #5 clk = ~clk;

    // The shared adder lives outside the controller.
    assign add_s = add_a + add_b + {31'd0, add_cin};

    sum_seq_ctrl #(.WIDTH(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_ops      (n_ops),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .carry_flag (carry_flag),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) hs_cnt++;
        if (rst_n && sum_valid) sv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int n, input bit poke);
        longint      t;
        logic [31:0] es;
        logic        ec;
        int          h0;
        int          s0;
        t  = 0;
        ec = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = t + longint'(q_ops[i]);
            if (t >= 64'h1_0000_0000) begin
                t  = t - 64'h1_0000_0000;
                ec = 1'b1;
            end
        end
        es = t[31:0];
        h0 = hs_cnt;
        s0 = sv_cnt;
        @(posedge clk); #1;
        start    = 1'b1;
        n_ops    = 8'(n);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < q_gaps[i]; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(negedge clk);
                chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
                chk("gap_sum_valid", {31'd0, sum_valid}, 32'd0);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = q_ops[i];
            if (poke && i == 1) begin
                start = 1'b1;
                n_ops = 8'd5;
            end
            @(negedge clk);
            chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
            chk("acc_busy", {31'd0, busy}, 32'd1);
            chk("acc_sum_valid", {31'd0, sum_valid}, 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = $urandom;
        @(negedge clk);
        chk("done_sum_valid", {31'd0, sum_valid}, 32'd1);
        chk("done_sum_out", sum_out, es);
        chk("done_carry", {31'd0, carry_flag}, {31'd0, ec});
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("handshakes", 32'(hs_cnt - h0), 32'(n));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_sum_hold", sum_out, es);
        chk("post_carry_hold", {31'd0, carry_flag}, {31'd0, ec});
        chk("strobe_count", 32'(sv_cnt - s0), 32'd1);
        last_sum = es;
        q_ops.delete();
        q_gaps.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        n_ops    = 8'd0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sum_out", sum_out, 32'd0);
        chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_carry", {31'd0, carry_flag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);

        q_ops = '{32'h10, 32'h20, 32'h30};
        q_gaps = '{0, 0, 0};
        run_job(3, 1'b0);

        q_ops = '{32'hFFFF_FFFF, 32'h0000_0002};
        q_gaps = '{0, 0};
        run_job(2, 1'b0);

        q_ops = '{32'd1, 32'd1};
        q_gaps = '{0, 0};
        run_job(2, 1'b0);

        q_ops = '{32'h1234_5678, 32'h0BAD_F00D, 32'h7777_0001};
        q_gaps = '{0, 2, 5};
        run_job(3, 1'b0);

        run_job(0, 1'b0);

        // Reset in the middle of a job that has already wrapped.
        @(posedge clk); #1;
        start = 1'b1;
        n_ops = 8'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_data = 32'd5;
        @(posedge clk); #1;
        in_data = 32'd9;
        @(negedge clk);
        chk("pre_rst_carry", {31'd0, carry_flag}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sum_out", sum_out, 32'd0);
        chk("midrst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("midrst_carry", {31'd0, carry_flag}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        q_ops = '{32'd5, 32'd7};
        q_gaps = '{0, 0};
        run_job(2, 1'b0);

        // Abort after one of three operands with a fresh operand offered.
        hs0 = hs_cnt;
        sv0 = sv_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        n_ops = 8'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h11;
        @(posedge clk); #1;
        abort   = 1'b1;
        in_data = 32'h22;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_sum_valid", {31'd0, sum_valid}, 32'd0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum_hold", sum_out, last_sum);
        chk("abort_handshakes", 32'(hs_cnt - hs0), 32'd1);
        chk("abort_strobes", 32'(sv_cnt - sv0), 32'd0);

        q_ops = '{32'd100, 32'd200, 32'd300};
        q_gaps = '{0, 1, 0};
        run_job(3, 1'b1);

        for (int i = 0; i < 255; i++) begin
            q_ops.push_back(32'd1);
            q_gaps.push_back(0);
        end
        run_job(255, 1'b0);

        for (int j = 0; j < 5; j++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                q_ops.push_back($urandom);
                q_gaps.push_back(int'($urandom_range(0, 3)));
            end
            run_job(n, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
